// File: rtl/divu_sequencer.sv
// rtl/divu_sequencer.sv - DIVU controller: latches operands, sequences the divider, captures HI/LO.
// Optional DIVU_ZERO_BYPASS_EN: a zero divisor skips the divider and yields hi=dividend, lo=all ones.
module divu_sequencer #(
  parameter int         ITER    = 32,
  parameter logic [5:0] OP_DIVU = 6'b011011,
  parameter logic [5:0] OP_OUT  = 6'b111111,
  parameter logic [5:0] OP_NOP  = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic [1:0]  hilo_we,
  input  logic [31:0] hilo_wdata,
  output logic [31:0] div_dataA,
  output logic [31:0] div_dataB,
  output logic        div_load,
  output logic [5:0]  div_signal,
  input  logic [63:0] div_result,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, OUTP, CAPT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   data_a_q, data_a_d;
  logic [31:0]   data_b_q, data_b_d;
  logic          div_load_q, div_load_d;
  logic [5:0]    div_signal_q, div_signal_d;
  logic          done_q, done_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    data_a_d     = data_a_q;
    data_b_d     = data_b_q;
    div_load_d   = 1'b0;
    div_signal_d = OP_NOP;
    done_d       = 1'b0;
    hi_d         = hi_q;
    lo_d         = lo_q;

    case (state_q)
      IDLE: begin
        count_d = '0;
        if (hilo_we[1]) hi_d = hilo_wdata;
        if (hilo_we[0]) lo_d = hilo_wdata;
        if (start && !flush) begin
          data_a_d   = op_a;
          data_b_d   = op_b;
          div_load_d = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        count_d      = '0;
        state_d      = RUN;
        div_signal_d = OP_DIVU;
`ifdef DIVU_ZERO_BYPASS_EN
        if (data_b_q == 32'd0) begin
          state_d      = CAPT;
          div_signal_d = OP_NOP;
        end
`endif
      end
      RUN: begin
        // div_signal is registered, so the opcode for the next cycle is chosen here.
        if (count_q == CW'(ITER - 1)) begin
          count_d      = '0;
          state_d      = OUTP;
          div_signal_d = OP_OUT;
        end else begin
          count_d      = count_q + CW'(1);
          div_signal_d = OP_DIVU;
        end
      end
      OUTP: state_d = CAPT;
      CAPT: begin
        state_d = IDLE;
        done_d  = 1'b1;
        hi_d    = div_result[63:32];
        lo_d    = div_result[31:0];
`ifdef DIVU_ZERO_BYPASS_EN
        if (data_b_q == 32'd0) begin
          hi_d = data_a_q;
          lo_d = 32'hFFFF_FFFF;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over everything in flight, including the final capture.
    if (flush && (state_q != IDLE)) begin
      state_d      = IDLE;
      count_d      = '0;
      div_load_d   = 1'b0;
      div_signal_d = OP_NOP;
      done_d       = 1'b0;
      hi_d         = hi_q;
      lo_d         = lo_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      data_a_q     <= '0;
      data_b_q     <= '0;
      div_load_q   <= 1'b0;
      div_signal_q <= OP_NOP;
      done_q       <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      data_a_q     <= data_a_d;
      data_b_q     <= data_b_d;
      div_load_q   <= div_load_d;
      div_signal_q <= div_signal_d;
      done_q       <= done_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign div_dataA  = data_a_q;
  assign div_dataB  = data_b_q;
  assign div_load   = div_load_q;
  assign div_signal = div_signal_q;
  assign done       = done_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule

// File: tb/tb_divu_sequencer.sv
// tb/tb_divu_sequencer.sv - directed table-driven bench for divu_sequencer.
module tb_divu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic [1:0]  hilo_we;
  logic [31:0] hilo_wdata;
  logic [31:0] div_dataA, div_dataB;
  logic        div_load;
  logic [5:0]  div_signal;
  logic [63:0] div_result;
  logic        busy, done;
  logic [31:0] hi, lo;

  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_CAFE_F00D;

  int total = 0;
  int bad   = 0;

  divu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .flush(flush), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
    .div_dataA(div_dataA), .div_dataB(div_dataB), .div_load(div_load),
    .div_signal(div_signal), .div_result(div_result), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          edone;
    int          edivu;
    int          eout;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Edge k is the k-th rising edge after the one that samples start (k=0).
  task automatic run_vec(input vec_t v);
    int load_n = 0, divu_n = 0, out_n = 0, busy_n = 0, done_n = 0, done_k = -1;
    logic [31:0] hi_s = '0, lo_s = '0, a_s = '0;
    @(negedge clk);
    start = 1'b1; op_a = v.a; op_b = v.b;
    for (int k = 0; k < 46; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin start = 1'b0; op_a = '0; op_b = '0; end
      if (k == 1) a_s = div_dataA;
      if (div_load) load_n++;
      if (div_signal == 6'd27) divu_n++;
      if (div_signal == 6'd63) out_n++;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_k < 0) begin done_k = k; hi_s = hi; lo_s = lo; end
      end
      div_result = (k == 34) ? v.res : JUNK;
    end
    chk("done_edge", 64'(done_k), 64'(v.edone));
    chk("done_count", 64'(done_n), 64'd1);
    chk("hi", 64'(hi_s), 64'(v.ehi));
    chk("lo", 64'(lo_s), 64'(v.elo));
    chk("load_pulses", 64'(load_n), 64'd1);
    chk("divu_cycles", 64'(divu_n), 64'(v.edivu));
    chk("out_cycles", 64'(out_n), 64'(v.eout));
    chk("busy_cycles", 64'(busy_n), 64'(v.edone));
    chk("dataA_latched", 64'(a_s), 64'(v.a));
  endtask

  task automatic hilo_write(input logic [31:0] d);
    @(negedge clk);
    hilo_we = 2'b11; hilo_wdata = d;
    @(posedge clk); #1;
    hilo_we = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    int loads;
    reset = 1'b0; start = 1'b0; op_a = '0; op_b = '0; flush = 1'b0;
    hilo_we = 2'b00; hilo_wdata = '0; div_result = JUNK;

    vecs[0] = '{32'd100, 32'd7, {32'd2, 32'd14}, 32'd2, 32'd14, 35, 32, 1};
    vecs[1] = '{32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 32'hF, 32'h0FFF_FFFF, 35, 32, 1};
    vecs[2] = '{32'd1000, 32'd1000, {32'd0, 32'd1}, 32'd0, 32'd1, 35, 32, 1};
`ifdef DIVU_ZERO_BYPASS_EN
    vecs[3] = '{32'd55, 32'd0, JUNK, 32'd55, 32'hFFFF_FFFF, 2, 0, 0};
`else
    vecs[3] = '{32'd55, 32'd0, {32'd55, 32'hFFFF_FFFF}, 32'd55, 32'hFFFF_FFFF, 35, 32, 1};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_signal", 64'(div_signal), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Flush at RUN count 10: no done, HI/LO preserved.
    hilo_write(32'h1234_5678);
    chk("hilo_pre_flush", {hi, lo}, {32'h1234_5678, 32'h1234_5678});
    @(negedge clk); start = 1'b1; op_a = 32'd100; op_b = 32'd7;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_signal", 64'(div_signal), 64'd0);
    div_result = {32'd2, 32'd14};
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    chk("flush_no_done", 64'(n), 64'd0);
    chk("flush_hilo", {hi, lo}, {32'h1234_5678, 32'h1234_5678});

    // start held high: a new divide can only begin the edge after done.
    @(negedge clk); start = 1'b1; op_a = 32'd100; op_b = 32'd7;
    n = 0; loads = 0;
    for (int k = 0; k < 72; k++) begin
      @(posedge clk); #1;
      if (done) n++;
      if (div_load) loads++;
    end
    start = 1'b0;
    chk("cont_done", 64'(n), 64'd2);
    chk("cont_loads", 64'(loads), 64'd2);
    chk("cont_hilo", {hi, lo}, {32'd2, 32'd14});
    repeat (2) @(posedge clk);
    div_result = JUNK;

    // mthi/mtlo during busy is dropped; in IDLE it lands.
    @(negedge clk); start = 1'b1; op_a = 32'd1000; op_b = 32'd1000;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 5) begin hilo_we = 2'b11; hilo_wdata = 32'hA5A5_A5A5; end
      if (k == 6) begin
        hilo_we = 2'b00;
        chk("busy_write_ignored", {hi, lo}, {32'd2, 32'd14});
      end
      div_result = (k == 34) ? {32'd0, 32'd1} : JUNK;
    end
    chk("after_busy_write", {hi, lo}, {32'd0, 32'd1});
    hilo_write(32'hA5A5_A5A5);
    chk("idle_write", {hi, lo}, {32'hA5A5_A5A5, 32'hA5A5_A5A5});

    // Write and start together: write lands now, divide overwrites later.
    @(negedge clk);
    start = 1'b1; op_a = 32'd100; op_b = 32'd7; hilo_we = 2'b11; hilo_wdata = 32'h1111_1111;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0; hilo_we = 2'b00;
      if (k == 0) chk("write_with_start", {hi, lo}, {32'h1111_1111, 32'h1111_1111});
      div_result = (k == 34) ? {32'd2, 32'd14} : JUNK;
    end
    chk("overwrite_after", {hi, lo}, {32'd2, 32'd14});

    // Asynchronous reset in the middle of RUN.
    @(negedge clk); start = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'h10;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_outs", {26'd0, div_load, done, div_signal, hi, lo}, 64'd0);
    chk("midrst_data", {div_dataA, div_dataB}, 64'd0);
    @(negedge clk); reset = 1'b1;
    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
